// File: rtl/tf_stage_seq.sv
`timescale 1ns/1ps
// Control sequencer for the twiddle-factor generator: seed load, per-stage read
// strobes with depth/iteration/stage counters, final radix-k2 stage, drain, done.
module tf_stage_seq #(
  parameter int D_WIDTH   = 64,
  parameter int STAGES    = 3,
  parameter int DEPTH     = 8,
  parameter int ITE       = 16,
  parameter int SEED_CYC  = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               TF_wen,
  output logic               TF_ren,
  output logic [2:0]         it_depth_cnt,
  output logic [2:0]         l,
  output logic [D_WIDTH-1:0] ite_sw_cnt,
  output logic [D_WIDTH-1:0] ite_sw_cnt_ite3,
  output logic               LAST_STAGE,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {IDLE, SEED, RUN, LAST, DRAIN, DONE} state_t;

  localparam logic [2:0]         DEPTH_LAST = 3'(DEPTH - 1);
  localparam logic [2:0]         STAGE_LAST = 3'(STAGES - 1);
  localparam logic [D_WIDTH-1:0] ITE_LAST   = D_WIDTH'(ITE - 1);
  localparam logic [D_WIDTH-1:0] ITE_ONE    = D_WIDTH'(1);
  localparam logic [31:0]        SEED_LAST  = 32'(SEED_CYC - 1);
  localparam logic [31:0]        DRAIN_LAST = 32'(DRAIN_CYC - 1);

  state_t             state, state_n;
  logic [31:0]        seed_cnt, seed_cnt_n, drain_cnt, drain_cnt_n;
  logic [2:0]         depth_n, l_n;
  logic [D_WIDTH-1:0] ite_n, grp_n;
  logic               wen_n, ren_n;

  assign state_dbg = state;

  // Strobe semantics: a cycle with TF_wen/TF_ren high is one issued seed write or
  // read; counters advance at the edge that closes an issued cycle. hold sampled
  // at an edge blanks the following cycle, so every hold edge costs one cycle.
  always_comb begin
    state_n     = state;
    seed_cnt_n  = seed_cnt;
    drain_cnt_n = drain_cnt;
    depth_n     = it_depth_cnt;
    l_n         = l;
    ite_n       = ite_sw_cnt;
    grp_n       = ite_sw_cnt_ite3;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = SEED;
          seed_cnt_n = '0;
          depth_n    = '0;
          l_n        = '0;
          ite_n      = '0;
          grp_n      = '0;
        end
      end
      SEED: begin
        if (TF_wen) begin
          if (seed_cnt == SEED_LAST) begin
            state_n    = RUN;
            seed_cnt_n = '0;
          end else begin
            seed_cnt_n = seed_cnt + 32'd1;
          end
        end
      end
      RUN: begin
        if (TF_ren) begin
          if (it_depth_cnt == DEPTH_LAST) begin
            depth_n = '0;
            if (ite_sw_cnt == ITE_LAST) begin
              ite_n = '0;
              grp_n = '0;
              l_n   = l + 3'd1;
              if (l == STAGE_LAST) state_n = LAST;
            end else begin
              ite_n = ite_sw_cnt + ITE_ONE;
              if (ite_sw_cnt[2:0] == 3'd7) grp_n = ite_sw_cnt_ite3 + ITE_ONE;
            end
          end else begin
            depth_n = it_depth_cnt + 3'd1;
          end
        end
      end
      LAST: begin
        if (TF_ren) begin
          if (it_depth_cnt == DEPTH_LAST) begin
            depth_n     = '0;
            drain_cnt_n = '0;
            state_n     = DRAIN;
          end else begin
            depth_n = it_depth_cnt + 3'd1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          drain_cnt_n = '0;
          state_n     = DONE;
        end else begin
          drain_cnt_n = drain_cnt + 32'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    wen_n = (state_n == SEED) && !hold;
    ren_n = ((state_n == RUN) || (state_n == LAST)) && !hold;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      seed_cnt        <= '0;
      drain_cnt       <= '0;
      it_depth_cnt    <= '0;
      l               <= '0;
      ite_sw_cnt      <= '0;
      ite_sw_cnt_ite3 <= '0;
      TF_wen          <= 1'b0;
      TF_ren          <= 1'b0;
      LAST_STAGE      <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      seed_cnt        <= seed_cnt_n;
      drain_cnt       <= drain_cnt_n;
      it_depth_cnt    <= depth_n;
      l               <= l_n;
      ite_sw_cnt      <= ite_n;
      ite_sw_cnt_ite3 <= grp_n;
      TF_wen          <= wen_n;
      TF_ren          <= ren_n;
      LAST_STAGE      <= (state_n == LAST);
      busy            <= (state_n != IDLE) && (state_n != DONE);
      done            <= (state_n == DONE);
    end
  end

endmodule
